// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write port of the loader.
// The master view belongs to the loader; the slave view to the byte source and memory.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;

    modport master (
        input  byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        output byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: length-prefixed little-endian byte frame in, word writes out,
// core held in reset until the payload checksum verifies.
module imem_loader #(
    parameter int ADDR_WIDTH    = 8,
    parameter bit HOLD_AT_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    imem_loader_if.master        bus,
    output logic                 cpu_hold,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_CHECK
    } state_t;

    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_WIDTH);

    state_t                state_q;
    state_t                state_d;
    logic [7:0]            len_lo_q;
    logic [15:0]           len_q;
    logic [ADDR_WIDTH-1:0] index_q;
    logic [1:0]            byte_cnt_q;
    logic [31:0]           shift_q;
    logic [7:0]            csum_q;

    logic                  accept;
    logic [15:0]           len_rx;
    logic                  len_bad;
    logic                  last_word;

    assign accept    = bus.byte_valid && bus.byte_ready;
    assign len_rx    = {bus.byte_data, len_lo_q};
    assign len_bad   = (len_rx == 16'd0) || ({1'b0, len_rx} > DEPTH);
    // Compared at 17 bits so N == DEPTH ends on the top address without wrapping.
    assign last_word = (17'(index_q) == (17'(len_q) - 17'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values, independent of process ordering.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: defaulting every combinational output before the case prevents
        // latch inference on paths that do not assign it.
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start) state_d = S_LEN_LO;
            S_LEN_LO: if (accept) state_d = S_LEN_HI;
            S_LEN_HI: if (accept) state_d = len_bad ? S_IDLE : S_DATA;
            S_DATA:   if (accept && byte_cnt_q == 2'd3) state_d = S_WRITE;
            S_WRITE:  state_d = last_word ? S_CHECK : S_DATA;
            S_CHECK:  if (accept) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.byte_ready = 1'b0;
        bus.imem_we    = 1'b0;
        busy           = (state_q != S_IDLE);
        unique case (state_q)
            S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK: bus.byte_ready = 1'b1;
            S_WRITE:                             bus.imem_we    = 1'b1;
            default:                             ;
        endcase
    end

    assign bus.imem_addr  = index_q;
    assign bus.imem_wdata = shift_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_lo_q   <= '0;
            len_q      <= '0;
            index_q    <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            csum_q     <= '0;
            cpu_hold   <= HOLD_AT_RESET;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        error      <= 1'b0;
                        csum_q     <= '0;
                        index_q    <= '0;
                        byte_cnt_q <= '0;
                        cpu_hold   <= 1'b1;
                    end
                end
                S_LEN_LO: begin
                    if (accept) len_lo_q <= bus.byte_data;
                end
                S_LEN_HI: begin
                    if (accept) begin
                        len_q <= len_rx;
                        if (len_bad) error <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        // Right shift: after four bytes the first one sits in bits [7:0].
                        shift_q    <= {bus.byte_data, shift_q[31:8]};
                        csum_q     <= csum_q + bus.byte_data;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                    end
                end
                S_WRITE: begin
                    index_q <= index_q + ADDR_WIDTH'(1);
                end
                S_CHECK: begin
                    if (accept) begin
                        if (bus.byte_data == csum_q) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as bytes are driven
// and popped when the loader strobes imem_we.
module tb_imem_loader;

    localparam int AW = 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic start    = 1'b0;
    logic cpu_hold;
    logic busy;
    logic done;
    logic error;

    imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

    imem_loader #(
        .ADDR_WIDTH   (AW),
        .HOLD_AT_RESET(1'b1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bus     (bus),
        .cpu_hold(cpu_hold),
        .busy    (busy),
        .done    (done),
        .error   (error)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_pass   = 0;
    int            we_cnt   = 0;
    int            done_cnt = 0;
    logic [AW-1:0] last_addr;
    logic [31:0]   mem   [256];
    logic [31:0]   words [256];
    wr_t           sb [$];
    wr_t           exp_wr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    // Memory model on the write port; contents persist across sessions like the real array.
    always @(posedge clk) begin
        if (rst_n && bus.imem_we) mem[bus.imem_addr] <= bus.imem_wdata;
    end

    always @(negedge clk) begin
        if (rst_n && done) done_cnt++;
        if (rst_n && bus.imem_we) begin
            we_cnt++;
            last_addr = bus.imem_addr;
            check("ready_in_write", bus.byte_ready, 0);
            if (sb.size() == 0) begin
                check("unexpected_write", bus.imem_we, 0);
            end else begin
                exp_wr = sb.pop_front();
                check("wr_addr", bus.imem_addr, exp_wr.addr);
                check("wr_data", bus.imem_wdata, exp_wr.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic r;
        int   n;
        if (gap > 0) begin
            bus.byte_valid = 1'b0;
            repeat (gap) tick();
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        r = 1'b0;
        n = 0;
        while (!r && n < 20) begin
            @(negedge clk);
            r = bus.byte_ready;
            tick();
            n++;
        end
        if (!r) check("ready_timeout", r, 1);
    endtask

    task automatic pulse_start();
        bus.byte_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, bus.byte_ready, 0);
        check({tag, "_we"},    bus.imem_we, 0);
        check({tag, "_addr"},  bus.imem_addr, 0);
        check({tag, "_wdata"}, bus.imem_wdata, 0);
        check({tag, "_hold"},  cpu_hold, 1);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_error"}, error, 0);
    endtask

    // Sends a full frame of words[0..n-1]; glitch_at >= 0 pulses start inside DATA before that word.
    task automatic send_frame(input int n, input logic [7:0] cs_delta, input int max_gap,
                              input int glitch_at);
        logic [7:0] sum;
        logic [7:0] b;
        int         gap;
        sum = '0;
        send_byte(n[7:0], 0);
        send_byte(n[15:8], 0);
        for (int i = 0; i < n; i++) begin
            if (i == glitch_at) begin
                bus.byte_valid = 1'b0;
                tick();
                pulse_start();
                check("ignored_start_busy", busy, 1);
                check("ignored_start_error", error, 0);
            end
            sb.push_back(wr_t'{AW'(i), words[i]});
            for (int k = 0; k < 4; k++) begin
                b   = words[i][8*k +: 8];
                sum = sum + b;
                gap = (k == 0) ? 0 : int'($urandom_range(max_gap, 0));
                send_byte(b, gap);
            end
        end
        send_byte(sum + cs_delta, int'($urandom_range(max_gap, 0)));
        bus.byte_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int we0;
        int done0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = '0;
        repeat (3) tick();
        check_reset_values("reset");
        rst_n = 1'b1;
        tick();

        // Nominal load
        words[0] = 32'h0010_0093;
        words[1] = 32'h0020_0113;
        we0 = we_cnt; done0 = done_cnt;
        pulse_start();
        check("nom_hold_on_start", cpu_hold, 1);
        check("nom_busy_on_start", busy, 1);
        send_frame(2, 8'd0, 0, -1);
        check("nom_done", done, 1);
        check("nom_hold_released", cpu_hold, 0);
        check("nom_error", error, 0);
        tick();
        check("nom_done_pulse", done, 0);
        check("nom_idle", busy, 0);
        check("nom_writes", we_cnt - we0, 2);
        check("nom_done_count", done_cnt - done0, 1);
        check("nom_mem0", mem[0], 32'h0010_0093);
        check("nom_mem1", mem[1], 32'h0020_0113);

        // Bad checksum: D8 instead of D7
        we0 = we_cnt; done0 = done_cnt;
        pulse_start();
        send_frame(2, 8'd1, 0, -1);
        tick();
        check("badcs_error", error, 1);
        check("badcs_hold", cpu_hold, 1);
        check("badcs_done_count", done_cnt - done0, 0);
        check("badcs_writes", we_cnt - we0, 2);

        // Bad length: N=0, then N=257
        we0 = we_cnt;
        pulse_start();
        check("badlen_error_cleared", error, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        bus.byte_valid = 1'b0;
        check("badlen0_error", error, 1);
        check("badlen0_idle", busy, 0);
        pulse_start();
        check("badlen_restart_error", error, 0);
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        bus.byte_valid = 1'b0;
        check("badlen257_error", error, 1);
        check("badlen257_idle", busy, 0);
        repeat (3) tick();
        check("badlen_writes", we_cnt - we0, 0);

        // Handshake: random gaps, valid held high into each WRITE
        we0 = we_cnt;
        pulse_start();
        send_frame(2, 8'd0, 3, -1);
        check("hs_done", done, 1);
        check("hs_error", error, 0);
        tick();
        check("hs_writes", we_cnt - we0, 2);
        check("hs_mem0", mem[0], 32'h0010_0093);
        check("hs_mem1", mem[1], 32'h0020_0113);

        // Reset mid-DATA, right after the 6th byte
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h93, 0);
        send_byte(8'h00, 0);
        send_byte(8'h10, 0);
        send_byte(8'h00, 0);
        bus.byte_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        pulse_start();
        send_frame(2, 8'd0, 0, -1);
        check("midrst_reload_done", done, 1);
        check("midrst_reload_hold", cpu_hold, 0);
        tick();

        // Full depth with a start pulse inside DATA
        for (int i = 0; i < 256; i++) words[i] = 32'(i);
        we0 = we_cnt;
        pulse_start();
        send_frame(256, 8'd0, 0, 10);
        check("full_done", done, 1);
        check("full_error", error, 0);
        check("full_hold", cpu_hold, 0);
        tick();
        check("full_writes", we_cnt - we0, 256);
        check("full_last_addr", last_addr, 8'hFF);
        check("full_mem_top", mem[255], 32'd255);
        check("full_mem_mid", mem[100], 32'd100);
        check("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
